done_cycle_ctrl: RTL and testbench

DONE_CYCLE_CTRL -- requirements
Module: DoneCycle

---
 rtl/done_cycle_ctrl.sv | 46 ++++
 tb/tb_done_cycle_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/done_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : done_cycle_ctrl
// Purpose  : Programmable running-cycle down-counter; done flags the end of a
//            count or an idle block.
// Revision : 1.0 - initial release
// ============================================================================
module done_cycle_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic              running_i,
    input  logic [DATA_W-1:0] amount_i,
    output logic              done_o
);

    localparam logic [DATA_W-1:0] C_ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] C_ZERO = '0;

    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] cnt_d;

    // A load wins over a decrement; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (run_i) begin
            cnt_d = amount_i;
        end else if (running_i && (cnt_q != C_ZERO)) begin
            cnt_d = cnt_q - C_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= C_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == C_ZERO);

endmodule
`default_nettype wire

// File: tb/tb_done_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_done_cycle_ctrl
// Purpose  : Directed self-checking bench for done_cycle_ctrl (DATA_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_done_cycle_ctrl;

    localparam int unsigned DATA_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              run = 1'b0;
    logic              running = 1'b0;
    logic [DATA_W-1:0] amount = '0;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a count is finished once the number of running edges since the
    // last load reaches the loaded amount.
    int m_amt = 0;
    int m_ran = 0;

    done_cycle_ctrl #(.DATA_W(DATA_W)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .run_i     (run),
        .running_i (running),
        .amount_i  (amount),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_amt <= 0;
            m_ran <= 0;
        end else if (run) begin
            m_amt <= int'(amount);
            m_ran <= 0;
        end else if (running) begin
            m_ran <= m_ran + 1;
        end
    end

    always @(negedge clk) begin
        n_cmp = n_cmp + 1;
        if ($isunknown(done) || (done !== (m_ran >= m_amt))) begin
            n_bad = n_bad + 1;
            $display("FAIL model_cmp t=%0t done=%b expected=%b", $time, done, (m_ran >= m_amt));
        end
    end

    task automatic check(input string name, input logic got, input logic exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp = n_cmp + 1;
        if (got != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Counts running edges until done rises; bounded so a stuck DUT still ends.
    task automatic count_low(output int n);
        n = 0;
        while (done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        // Reset with a non-zero amount present.
        amount = 4'hF;
        #1 rst_n = 1'b0;
        #1 check("reset_async_done", done, 1'b1);
        @(negedge clk);
        check("reset_during_done", done, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_reset", done, 1'b1);

        // Full-range count.
        run = 1'b1;
        @(negedge clk);
        check("full_loaded_low", done, 1'b0);
        run = 1'b0;
        running = 1'b1;
        count_low(n);
        check_int("full_count_15", n, 15);

        // amount=0 without run has no effect; then a second full run.
        amount = 4'h0;
        @(negedge clk);
        check("amount0_no_run_done", done, 1'b1);
        amount = 4'hF;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        count_low(n);
        check_int("second_count_15", n, 15);

        // Zero amount never drops done.
        amount = 4'h0;
        run = 1'b1;
        @(negedge clk);
        check("zero_amt_after_load", done, 1'b1);
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("zero_amt_stays_high", done, 1'b1);

        // Pause and resume: 2 running edges, 3 frozen, then 3 more.
        amount = 4'd5;
        running = 1'b0;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        running = 1'b1;
        repeat (2) @(negedge clk);
        running = 1'b0;
        repeat (3) @(negedge clk);
        check("paused_low", done, 1'b0);
        running = 1'b1;
        count_low(n);
        check_int("resume_count_3", n, 3);

        // Restart mid-count with run and running both high; later amount
        // changes must not disturb the active count.
        amount = 4'd5;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        amount = 4'd2;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        amount = 4'd7;
        count_low(n);
        check_int("restart_count_2", n, 2);

        // Asynchronous reset mid-count.
        amount = 4'd10;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_count_low", done, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_immediate", done, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_pending_after_reset", done, 1'b1);

        running = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
